// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 matrix keypad scanner.
// Key code encoding follows the seven-segment key decoder: 0-9, 10 = '*', 11 = '#'.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    EVAL
  } state_t;

  // Returns KEY_NONE when rows is not exactly one-hot or col is out of range.
  function automatic logic [3:0] key_code(input logic [1:0] col, input logic [3:0] rows);
    logic [1:0] row;
    logic       one_hot;
    logic [3:0] code;
    row     = 2'd0;
    one_hot = 1'b1;
    code    = KEY_NONE;
    case (rows)
      4'b0001: row = 2'd0;
      4'b0010: row = 2'd1;
      4'b0100: row = 2'd2;
      4'b1000: row = 2'd3;
      default: one_hot = 1'b0;
    endcase
    if (one_hot && (col != 2'd3)) begin
      if (row == 2'd3) begin
        case (col)
          2'd0:    code = 4'd10;
          2'd1:    code = 4'd0;
          default: code = 4'd11;
        endcase
      end else begin
        code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce filter applied once per full scan: a code must repeat for
// DEBOUNCE_SCANS consecutive scans before it replaces the reported key.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] scan_code,
  input  logic       eval,
  output logic [3:0] key_val,
  output logic       key_valid,
  output logic       press
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [3:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_val_q, key_val_d;
  logic          key_valid_q, key_valid_d;
  logic          press_q, press_d;
  logic          accept;

  always_comb begin
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    key_val_d   = key_val_q;
    key_valid_d = key_valid_q;
    press_d     = 1'b0;
    accept      = 1'b0;
    if (eval) begin
      if (scan_code == prev_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        prev_d = scan_code;
        cnt_d  = CW'(1);
      end
      // A held key keeps the count saturated but matches key_val, so it never re-fires.
      accept = (cnt_d == CNT_MAX) && (prev_d != key_val_q);
      if (accept) begin
        key_val_d   = prev_d;
        key_valid_d = (prev_d != KEY_NONE);
        press_d     = (prev_d != KEY_NONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= KEY_NONE;
      cnt_q       <= '0;
      key_val_q   <= KEY_NONE;
      key_valid_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      key_val_q   <= key_val_d;
      key_valid_q <= key_valid_d;
      press_q     <= press_d;
    end
  end

  assign key_val   = key_val_q;
  assign key_valid = key_valid_q;
  assign press     = press_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning controller for a 4-row x 3-column keypad. Drives one column
// at a time, folds the sampled rows into a per-scan key code and debounces it.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] ROWS,
  output logic [2:0] COLS,
  output logic [3:0] KEY_VAL,
  output logic       KEY_VALID,
  output logic       PRESS
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SCAN_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [2:0]    cols_q, cols_d;
  logic [3:0]    acc_q, acc_d;
  logic          conflict_q, conflict_d;
  logic [3:0]    col_code;

  assign col_code = key_code(col_idx_q, ROWS);

  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    settle_cnt_d = settle_cnt_q;
    cols_d       = cols_q;
    acc_d        = acc_q;
    conflict_d   = conflict_q;
    case (state_q)
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      SAMPLE: begin
        // Multi-row in a column or keys in two columns poisons the whole scan.
        if (ROWS != 4'b0000) begin
          if ((col_code == KEY_NONE) || (acc_q != KEY_NONE) || conflict_q) begin
            acc_d      = KEY_NONE;
            conflict_d = 1'b1;
          end else begin
            acc_d = col_code;
          end
        end
        if (col_idx_q < 2'd2) begin
          col_idx_d = col_idx_q + 2'd1;
          cols_d    = {cols_q[1:0], 1'b0};
          state_d   = SETTLE;
        end else begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        col_idx_d  = 2'd0;
        cols_d     = 3'b001;
        acc_d      = KEY_NONE;
        conflict_d = 1'b0;
        state_d    = SETTLE;
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= SETTLE;
      col_idx_q    <= 2'd0;
      settle_cnt_q <= '0;
      cols_q       <= 3'b001;
      acc_q        <= KEY_NONE;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      settle_cnt_q <= settle_cnt_d;
      cols_q       <= cols_d;
      acc_q        <= acc_d;
      conflict_q   <= conflict_d;
    end
  end

  assign COLS = cols_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (CLK),
    .rst      (RST),
    .scan_code(acc_q),
    .eval     (state_q == EVAL),
    .key_val  (KEY_VAL),
    .key_valid(KEY_VALID),
    .press    (PRESS)
  );

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scans a 4-row x 3-column matrix keypad by driving one column at a time and sampling the rows. Each full scan is reduced to a 4-bit key code, which is then debounced across several consecutive scans. The debounced code goes to the seven-segment key decoder (0-9, 10 = `*`, 11 = `#`, 4'hF = no key). The block also gives the MCU a one-cycle PRESS strobe, usable as an interrupt source.

Parameters:
- SCAN_CYCLES, 1000: clocks each column is driven before its rows are sampled (settle time); must be >= 1.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan codes required before the output updates; must be >= 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- ROWS  in  4  keypad row sense, active-high. ROWS[0] is the top row (1,2,3); ROWS[3] is the bottom row (`*`,0,#).
- COLS  out  3  column drive, one-hot, active-high. COLS[0] is the left column.
- KEY_VAL  out  4  debounced key code; 4'hF when no key.
- KEY_VALID  out  1  high while KEY_VAL != 4'hF.
- PRESS  out  1  one-cycle pulse when a new key is accepted.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). All outputs are registered.
- Reset values:
  - COLS = 3'b001, KEY_VAL = 4'hF, KEY_VALID = 0, PRESS = 0.
  - FSM in SETTLE, column index 0, settle counter 0.
  - Scan code accumulator = 4'hF, previous code = 4'hF, stable count = 0.
- FSM states:
  - SETTLE: hold COLS for SCAN_CYCLES clocks (counter 0..SCAN_CYCLES-1), then go to SAMPLE.
  - SAMPLE: one clock. Register ROWS for the current column and merge it into the scan code. If the column index is < 2, advance the index, shift COLS left and go to SETTLE. If the index is 2, go to EVAL.
  - EVAL: one clock. Apply the debounce filter, reset the column index to 0, set COLS = 3'b001, clear the accumulator to 4'hF, go to SETTLE.
- Scan period = 3*(SCAN_CYCLES+1)+1 clocks.
- Key code mapping (column, row):
  - (0,0)=1, (1,0)=2, (2,0)=3
  - (0,1)=4, (1,1)=5, (2,1)=6
  - (0,2)=7, (1,2)=8, (2,2)=9
  - (0,3)=10, (1,3)=0, (2,3)=11
- Multi-key: more than one asserted row in a column, or keys found in more than one column of the same scan, forces the scan code to 4'hF (treated as no key).
- Debounce filter, in EVAL:
  - If scan code == previous code: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: previous code <= scan code and stable count <= 1.
  - Acceptance occurs when the stable count equals DEBOUNCE_SCANS after this update and the previous code != KEY_VAL.
- On acceptance:
  - KEY_VAL <= code and KEY_VALID <= (code != 4'hF), both visible the clock after EVAL.
  - PRESS pulses for exactly that one clock, and only if code != 4'hF.
  - Release (code 4'hF) updates KEY_VAL/KEY_VALID without a PRESS pulse.
- Held key: no repeated PRESS pulses.
- Direct change from key A to key B (no intervening release): updates the outputs and pulses PRESS once B is stable.
- Maximum latency from a stable keypress to PRESS = (DEBOUNCE_SCANS+1) scan periods + 1 clock.
- RST mid-scan: on the next edge everything returns to reset values; any partially accumulated scan is discarded.
- ROWS are sampled only in SAMPLE. ROWS changes at any other time have no effect.

Decomposition:
- Package keypad_pkg holds:
  - KEY_NONE = 4'hF;
  - state enum {SETTLE, SAMPLE, EVAL};
  - a function mapping (column index, one-hot row) to the key code.
- Sub-module keypad_debounce contains the EVAL filter. Inputs: scan code, eval strobe. Outputs: KEY_VAL, KEY_VALID, PRESS. The scanner FSM stays in keypad_scan_ctrl.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, scan period 16 clocks):
1. Assert RST for 2 clocks, ROWS = 0 -> COLS = 001, KEY_VAL = F, KEY_VALID = 0, PRESS = 0. After release, COLS goes 001->010->100 every 5 clocks, EVAL occurs at clock 16, and COLS returns to 001.
2. Hold key '5' (ROWS[1] high while COLS[1] is driven) for 5 scans -> KEY_VAL = 5 and KEY_VALID = 1 the clock after the 3rd qualifying EVAL. PRESS is high for exactly 1 clock and never again while the key is held. Release -> KEY_VAL = F and KEY_VALID = 0 after 3 scans, with no PRESS.
3. Bounce: '8' present on alternating scans for 10 scans -> KEY_VAL stays F and PRESS never asserts.
4. Press `*`, `0` and `#` in sequence, each held for 4 scans with releases between -> KEY_VAL = 10, 0, 11 respectively; 3 PRESS pulses in total.
5. Hold '1' and '6' together for 5 scans -> KEY_VAL = F and no PRESS. Then hold '1' alone -> KEY_VAL = 1 with one PRESS.
6. While '9' is accepted (KEY_VAL = 9), assert RST in the middle of a SETTLE -> the next edge gives KEY_VAL = F, KEY_VALID = 0, COLS = 001. Holding '9' after RST is released re-accepts it, with one new PRESS after 3 scans.
